// File: rtl/wide_add_sequencer.sv
// Multi-word adder that walks WORDS 32-bit words through one registered 32-bit adder, rippling the carry.
// Optional signed-overflow output enabled by defining WIDE_ADD_OVF_EN.

module cascaded_sequential_adder (
  input  logic        clk,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s,
  output logic        cout
);

  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        cin_q;

  // Two register stages, no reset: operands are captured first, the sum one edge later.
  always_ff @(posedge clk) begin
    a_q         <= a;
    b_q         <= b;
    cin_q       <= cin;
    {cout, s}   <= {1'b0, a_q} + {1'b0, b_q} + {32'b0, cin_q};
  end

endmodule

module wide_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*WORDS-1:0]   in_a,
  input  logic [32*WORDS-1:0]   in_b,
  input  logic                  in_cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*WORDS-1:0]   out_sum,
  output logic                  out_cout,
`ifdef WIDE_ADD_OVF_EN
  output logic                  out_ovf,
`endif
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPT,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [WORDS-1:0][31:0]  opa_q, opa_d;
  logic [WORDS-1:0][31:0]  opb_q, opb_d;
  logic [WORDS-1:0][31:0]  sum_q, sum_d;
  logic                    carry_q, carry_d;
  logic [2:0]              k_q, k_d;
  logic                    cout_q, cout_d;
`ifdef WIDE_ADD_OVF_EN
  logic                    ovf_q, ovf_d;
`endif

  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_s;
  logic        add_cout;

  // Word select for the shared adder; driven in every state, only meaningful in ISSUE.
  always_comb begin
    add_a = '0;
    add_b = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (k_q == 3'(i)) begin
        add_a = opa_q[i];
        add_b = opb_q[i];
      end
    end
  end

  cascaded_sequential_adder u_adder (
    .clk  (clk),
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .s    (add_s),
    .cout (add_cout)
  );

  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    k_d       = k_q;
    cout_d    = cout_q;
`ifdef WIDE_ADD_OVF_EN
    ovf_d     = ovf_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          opa_d   = in_a;
          opb_d   = in_b;
          carry_d = in_cin;
          k_d     = 3'd0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy    = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        busy    = 1'b1;
        state_d = S_CAPT;
      end
      S_CAPT: begin
        busy = 1'b1;
        for (int i = 0; i < WORDS; i++) begin
          if (k_q == 3'(i)) begin
            sum_d[i] = add_s;
          end
        end
        carry_d = add_cout;
        if (k_q == 3'(WORDS - 1)) begin
          cout_d  = add_cout;
`ifdef WIDE_ADD_OVF_EN
          // Signed overflow: operands agree in sign but the top sum bit does not.
          ovf_d   = (opa_q[WORDS-1][31] == opb_q[WORDS-1][31]) &&
                    (add_s[31] != opa_q[WORDS-1][31]);
`endif
          state_d = S_DONE;
        end else begin
          k_d     = k_q + 3'd1;
          state_d = S_ISSUE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      k_q     <= 3'd0;
      cout_q  <= 1'b0;
`ifdef WIDE_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      cout_q  <= cout_d;
`ifdef WIDE_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign out_sum  = sum_q;
  assign out_cout = cout_q;
`ifdef WIDE_ADD_OVF_EN
  assign out_ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed testbench for wide_add_sequencer with WORDS=4; define WIDE_ADD_OVF_EN to also check out_ovf.

module tb_wide_add_sequencer;

  logic         clk;
  logic         rst;
  logic         inValid;
  logic         inReady;
  logic [127:0] inA;
  logic [127:0] inB;
  logic         inCin;
  logic         outValid;
  logic         outReady;
  logic [127:0] outSum;
  logic         outCout;
  logic         busy;
`ifdef WIDE_ADD_OVF_EN
  logic         outOvf;
`endif

  int nChecks = 0;
  int nBad    = 0;

  wide_add_sequencer #(.WORDS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .in_a      (inA),
    .in_b      (inB),
    .in_cin    (inCin),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_sum   (outSum),
    .out_cout  (outCout),
`ifdef WIDE_ADD_OVF_EN
    .out_ovf   (outOvf),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nBad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Starts from a negedge, presents the operands and returns just after the accepting edge.
  task automatic applyStimulus(input logic [127:0] a, input logic [127:0] b, input logic c);
    int n;
    @(negedge clk);
    inA = a;
    inB = b;
    inCin = c;
    inValid = 1'b1;
    n = 0;
    while (!inReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!inReady) checkOutput("acceptTimeout", {127'b0, inReady}, 128'd1);
    @(posedge clk);
    #1;
    inValid = 1'b0;
    inA = {4{32'hDEADBEEF}};
    inB = {4{32'hCAFEF00D}};
    inCin = 1'b1;
  endtask

  // Counts cycles after acceptance until out_valid is seen at a negedge.
  task automatic waitDone(output int cyc);
    cyc = 0;
    while (cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (outValid) break;
    end
    if (!outValid) checkOutput("doneTimeout", {127'b0, outValid}, 128'd1);
  endtask

  task automatic ackOutput();
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
  endtask

  task automatic runOp(input string tag, input logic [127:0] a, input logic [127:0] b, input logic c,
                       input logic [127:0] expSum, input logic expCout);
    int cyc;
    applyStimulus(a, b, c);
    waitDone(cyc);
    checkOutput({tag, "_latency"}, 128'(cyc), 128'd13);
    checkOutput({tag, "_sum"}, outSum, expSum);
    checkOutput({tag, "_cout"}, {127'b0, outCout}, {127'b0, expCout});
  endtask

  initial begin
    int cyc;
    int acc[2];
    int nAcc;
    int nDone;
    int n;
    logic [127:0] heldSum;

    rst = 1'b1;
    inValid = 1'b0;
    inA = '0;
    inB = '0;
    inCin = 1'b0;
    outReady = 1'b0;
    repeat (2) @(negedge clk);

    checkOutput("rst_inReady", {127'b0, inReady}, 128'd1);
    checkOutput("rst_outValid", {127'b0, outValid}, 128'd0);
    checkOutput("rst_busy", {127'b0, busy}, 128'd0);
    checkOutput("rst_sum", outSum, 128'd0);
    checkOutput("rst_cout", {127'b0, outCout}, 128'd0);
`ifdef WIDE_ADD_OVF_EN
    checkOutput("rst_ovf", {127'b0, outOvf}, 128'd0);
`endif
    rst = 1'b0;

    // Full carry ripple through all four words.
    runOp("allOnes", {128{1'b1}}, 128'd1, 1'b0, 128'd0, 1'b1);
`ifdef WIDE_ADD_OVF_EN
    checkOutput("allOnes_ovf", {127'b0, outOvf}, 128'd0);
`endif
    checkOutput("done_inReady", {127'b0, inReady}, 128'd0);
    ackOutput();
    @(negedge clk);
    checkOutput("ack_outValid", {127'b0, outValid}, 128'd0);
    checkOutput("ack_inReady", {127'b0, inReady}, 128'd1);

    runOp("lowHalf", 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0,
          128'h0000_0000_0000_0001_0000_0000_0000_0000, 1'b0);
    ackOutput();

    runOp("mixed", 128'h0000_0001_8000_0000_0000_0000_FFFF_FFFF,
                   128'h0000_0001_8000_0000_0000_0000_0000_0001, 1'b0,
                   128'h0000_0003_0000_0000_0000_0001_0000_0000, 1'b0);
    ackOutput();

    // Back-to-back operations with out_ready held high.
    @(negedge clk);
    inA = '0;
    inB = '0;
    inCin = 1'b1;
    inValid = 1'b1;
    outReady = 1'b1;
    nAcc = 0;
    nDone = 0;
    n = 0;
    while (nAcc < 2 && n < 60) begin
      if (outValid) begin
        nDone++;
        checkOutput("b2b_sum", outSum, 128'd1);
        checkOutput("b2b_cout", {127'b0, outCout}, 128'd0);
      end
      if (inReady && inValid) begin
        acc[nAcc] = n;
        nAcc++;
      end
      if (nAcc < 2) begin
        @(negedge clk);
        n++;
      end
    end
    checkOutput("b2b_accepts", 128'(nAcc), 128'd2);
    checkOutput("b2b_spacing", 128'(acc[1] - acc[0]), 128'd14);
    checkOutput("b2b_doneCycles", 128'(nDone), 128'd1);
    @(posedge clk);
    #1;
    inValid = 1'b0;
    waitDone(cyc);
    checkOutput("b2b2_latency", 128'(cyc), 128'd13);
    @(posedge clk);
    #1;
    outReady = 1'b0;

    // Back-pressure with a competing request waiting at the input.
    runOp("bp", 128'h0000_0000_0000_0000_0000_0001_0000_0000, 128'h0000_0000_0000_0000_0000_0001_0000_0000,
          1'b0, 128'h0000_0000_0000_0000_0000_0002_0000_0000, 1'b0);
    heldSum = outSum;
    inA = 128'd5;
    inB = 128'd7;
    inCin = 1'b0;
    inValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_outValid", {127'b0, outValid}, 128'd1);
      checkOutput("bp_inReady", {127'b0, inReady}, 128'd0);
      checkOutput("bp_sum", outSum, 128'h0000_0000_0000_0000_0000_0002_0000_0000);
      checkOutput("bp_cout", {127'b0, outCout}, 128'd0);
    end
    ackOutput();
    @(negedge clk);
    checkOutput("bp_idle_busy", {127'b0, busy}, 128'd0);
    checkOutput("bp_idle_inReady", {127'b0, inReady}, 128'd1);
    @(posedge clk);
    #1;
    inValid = 1'b0;
    waitDone(cyc);
    checkOutput("bp_next_latency", 128'(cyc), 128'd13);
    checkOutput("bp_next_sum", outSum, 128'd12);
    ackOutput();

    // Asynchronous reset in cycle 5 of an operation.
    applyStimulus({4{32'h1234_5678}}, {4{32'h1111_1111}}, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("midrst_busyBefore", {127'b0, busy}, 128'd1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_outValid", {127'b0, outValid}, 128'd0);
    checkOutput("midrst_busy", {127'b0, busy}, 128'd0);
    checkOutput("midrst_inReady", {127'b0, inReady}, 128'd1);
    @(negedge clk);
    rst = 1'b0;
    runOp("afterRst", 128'd1, 128'd2, 1'b0, 128'd3, 1'b0);
    ackOutput();

`ifdef WIDE_ADD_OVF_EN
    runOp("ovfPos", {1'b0, {127{1'b1}}}, 128'd1, 1'b0, {1'b1, 127'b0}, 1'b0);
    checkOutput("ovfPos_ovf", {127'b0, outOvf}, 128'd1);
    ackOutput();
    runOp("ovfNeg", {128{1'b1}}, 128'd1, 1'b0, 128'd0, 1'b1);
    checkOutput("ovfNeg_ovf", {127'b0, outOvf}, 128'd0);
    ackOutput();
`endif

    if (heldSum !== 128'h0000_0000_0000_0000_0000_0002_0000_0000) begin
      checkOutput("bp_heldSum", heldSum, 128'h0000_0000_0000_0000_0000_0002_0000_0000);
    end

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule

// File: doc/wide_add_sequencer.md
# wide_add_sequencer

Multi-word adder controller that performs a WORDS×32-bit addition by sequencing a single instance of the team's 32-bit registered adder, `cascaded_sequential_adder`. It passes the carry out of each word into the next word. Operands arrive and results leave over valid/ready handshakes. The block sits between an operand source, such as a bignum/crypto front-end, and the shared 32-bit add datapath.

## Interface
- `WORDS`, default 4: number of 32-bit words per operand; legal range 2..8.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: operand bundle valid.
- `in_ready` output 1: high only in IDLE; a transfer happens when `in_valid && in_ready` at a rising edge.
- `in_a` input 32*WORDS: operand A; word k is bits [32k+31:32k].
- `in_b` input 32*WORDS: operand B.
- `in_cin` input 1: carry into word 0.
- `out_valid` output 1: result valid; high only in DONE.
- `out_ready` input 1: consumer accepts the result.
- `out_sum` output 32*WORDS: sum, modulo 2^(32*WORDS).
- `out_cout` output 1: carry out of the top word.
- `busy` output 1: high in ISSUE, WAIT and CAPT.

## Operation
- The adder instance inputs are driven from internal registers: `opa_q`, `opb_q`, `carry_q` and word index `k_q` (3 bits).
- Adder inputs are `a = opa_q[k_q]`, `b = opb_q[k_q]`, `cin = carry_q`. These inputs are driven in every state. Their values matter only in ISSUE.
- The adder has no reset and its output registers start undefined. Its `s`/`cout` are consumed only in CAPT, which always follows an ISSUE of the same word, so stale data is never used.
- IDLE: `in_ready`=1. On the input handshake:
  - latch `in_a`/`in_b` into `opa_q`/`opb_q`;
  - set `carry_q` ← `in_cin` and `k_q` ← 0;
  - go to ISSUE.
- ISSUE: present word k_q to the adder, then go to WAIT.
- WAIT: the adder captures its inputs; go to CAPT.
- CAPT: the adder `s`/`cout` is valid for word k_q.
  - Write `sum_q[k_q]` ← `s` and `carry_q` ← `cout`.
  - If k_q == WORDS-1, go to DONE with `out_cout` ← `cout`.
  - Otherwise k_q ← k_q+1 and go to ISSUE.
- DONE: `out_valid`=1 and `out_sum`/`out_cout` are held stable. On `out_ready`, go to IDLE.
- There is no same-cycle turnaround: `in_ready` is 0 in DONE, so a new operand is accepted no earlier than the cycle after the output handshake.
- `in_valid` is ignored outside IDLE, and `in_a`/`in_b` may change freely after acceptance.
- Width rules:
  - the sum wraps modulo 2^(32*WORDS);
  - `carry_q` is 1 bit;
  - `k_q` never exceeds WORDS-1.

## Timing
- Reset values:
  - state = IDLE, so `in_ready`=1;
  - `out_valid`=0, `busy`=0;
  - `out_sum`=0, `out_cout`=0;
  - `carry_q`=0, `k_q`=0.
- If the input handshake happens at the edge ending cycle 0, word k is in ISSUE in cycle 1+3k and in CAPT in cycle 3+3k.
- `out_valid` rises in cycle 3·WORDS+1. For WORDS=4 that is cycle 13, and throughput is one operation per 3·WORDS+2 cycles.
- Back-pressure: DONE persists indefinitely while `out_ready`=0.
- Reset mid-operation (any state): return to IDLE immediately and clear `out_valid` and `busy`. The partial result is discarded. The stale contents of the adder pipeline are harmless by construction.
- If `out_ready` is held high in advance, DONE still lasts exactly one cycle.

## Configuration
- Macro `WIDE_ADD_OVF_EN`.
  - Defined: adds output port `out_ovf` (1 bit, reset 0). It is the signed two's-complement overflow of the full-width add: `a_msb == b_msb && sum_msb != a_msb`, taken from `opa_q`/`opb_q`/the top sum word at the CAPT of word WORDS-1. It is valid and held with `out_valid`.
  - Undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
All scenarios use WORDS=4.
- All-ones A + B=1, cin=0 → `out_sum`=0, `out_cout`=1, `out_valid` first high in cycle 13 after acceptance.
- A=0x0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, B=1 → `out_sum`=0x0000_0000_0000_0001_0000_0000_0000_0000, `out_cout`=0. This checks the carry crossing word boundaries.
- A=B=0, cin=1 → `out_sum`=1, `out_cout`=0. Back-to-back ops with `out_ready`=1 give a 14-cycle accept-to-accept spacing.
- Back-pressure: `out_ready`=0 for 5 cycles in DONE → `out_sum`/`out_cout` stable, `in_ready`=0. A new `in_valid` during that window is not accepted until after the output handshake.
- `rst` pulsed in cycle 5 of an op → `out_valid`=0, `busy`=0, `in_ready`=1 immediately. The next op (0x1 + 0x2) yields 0x3.
- `WIDE_ADD_OVF_EN` defined: A=0x7FFF…FFFF, B=1 → `out_ovf`=1. A=0xFFFF…FFFF, B=1 → `out_ovf`=0.
